// File: rtl/dff_pipe_bank.sv
// Parametrised pipeline register bank. Each stage holds a WIDTH-bit word and a
// travelling valid bit. The output stage has per-bit set and clear, and a scan
// mode turns every data flop into one serial chain.
module dff_pipe_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             V_IN,
    input  logic [WIDTH-1:0] SET_MASK,
    input  logic [WIDTH-1:0] CLR_MASK,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic             SO
);

    localparam int unsigned Last   = DEPTH - 1;
    localparam int unsigned ChainW = DEPTH * WIDTH;

    // Stage k, bit i sits at flat bit k*WIDTH+i, which is also its scan-chain position.
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [ChainW-1:0]           chain_q, chain_d;

    assign chain_q = stage_q;

    // Next-state: scan shift, or advance/hold followed by output-stage masks.
    always_comb begin
        chain_d = chain_q;
        valid_d = valid_q;
        if (SE) begin
            // One position per edge toward the output end; valid bits hold.
            chain_d = (chain_q << 1) | ChainW'(SI);
        end else if (EN) begin
            chain_d = (chain_q << WIDTH) | ChainW'(D);
            valid_d = (valid_q << 1) | DEPTH'(V_IN);
        end
        stage_d = chain_d;
        if (!SE) begin
            // Clear beats set; only the output stage's data is touched.
            stage_d[Last] = (stage_d[Last] | SET_MASK) & ~CLR_MASK;
        end
    end

    // State registers with synchronous reset that overrides every other control.
    always_ff @(posedge CLK) begin
        if (R) begin
            stage_q <= {DEPTH{RESET_VAL}};
            valid_q <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
        end
    end

    assign Q       = stage_q[Last];
    assign Q_VALID = valid_q[Last];
    assign SO      = stage_q[Last][WIDTH-1];

endmodule
